// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  typedef enum logic {NORMAL, FORCE} arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback / long-latency / register-file port bundle around the write arbiter.
interface regfile_write_arbiter_if
  import rf_arb_pkg::*;
();

  logic                  wb_we_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  lu_valid_i;
  logic                  lu_ready_o;
  logic [REG_ADDR_W-1:0] lu_rd_i;
  logic [XLEN-1:0]       lu_data_i;
  logic                  rf_we_o;
  logic [REG_ADDR_W-1:0] rf_rd_o;
  logic [XLEN-1:0]       rf_wd_o;
  logic                  stall_o;

  modport master (
    output wb_we_i, wb_rd_i, wb_data_i, lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o, rf_we_o, rf_rd_o, rf_wd_o, stall_o
  );

  modport slave (
    input  wb_we_i, wb_rd_i, wb_data_i, lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o, rf_we_o, rf_rd_o, rf_wd_o, stall_o
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of pending long-latency writes; head is registered, no fall-through.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  rf_wr_t                 wdata_i,
  input  logic                   pop_i,
  output rf_wr_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  rf_wr_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and a
// FIFO of long-latency results, with a starvation timer that forces a one-cycle drain.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [StarveW-1:0]    starve_q, starve_d;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;
  rf_wr_t                fifo_head, fifo_in;
  logic                  wb_req, lu_ready;
  logic                  rf_we, stall;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wd;

  assign lu_ready = ~reset_i & ~fifo_full;
  // Writes to x0 are accepted on the handshake but never enqueued.
  assign fifo_push = bus.lu_valid_i & lu_ready & (bus.lu_rd_i != '0);
  assign fifo_in   = '{rd: bus.lu_rd_i, data: bus.lu_data_i};
  assign wb_req    = bus.wb_we_i & (bus.wb_rd_i != '0);

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wd    = '0;
    stall    = 1'b0;
    fifo_pop = 1'b0;
    state_d  = NORMAL;
    starve_d = starve_q;
    if (!reset_i) begin
      if (state_q == FORCE && !fifo_empty) begin
        rf_we    = 1'b1;
        rf_rd    = fifo_head.rd;
        rf_wd    = fifo_head.data;
        stall    = 1'b1;
        fifo_pop = 1'b1;
      end else if (wb_req) begin
        rf_we = 1'b1;
        rf_rd = bus.wb_rd_i;
        rf_wd = bus.wb_data_i;
        if (!fifo_empty) begin
          if (starve_q == StarveW'(STARVE_LIMIT - 1)) state_d = FORCE;
          if (starve_q != '1) starve_d = starve_q + 1'b1;
        end
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_rd    = fifo_head.rd;
        rf_wd    = fifo_head.data;
        fifo_pop = 1'b1;
      end
      if (fifo_pop || fifo_empty) starve_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign bus.lu_ready_o = lu_ready;
  assign bus.rf_we_o    = rf_we;
  assign bus.rf_rd_o    = rf_rd;
  assign bus.rf_wd_o    = rf_wd;
  assign bus.stall_o    = stall;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with DEPTH=2, STARVE_LIMIT=4.
module tb_regfile_write_arbiter;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, outputs settle 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    bus.lu_valid_i = 1'b1;
    bus.lu_rd_i    = rd;
    bus.lu_data_i  = data;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we_i   = we;
    bus.wb_rd_i   = rd;
    bus.wb_data_i = data;
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] wd, input logic st);
    check({tag, ".we"}, 32'(bus.rf_we_o), 32'(we));
    check({tag, ".rd"}, 32'(bus.rf_rd_o), 32'(rd));
    check({tag, ".wd"}, bus.rf_wd_o, wd);
    check({tag, ".stall"}, 32'(bus.stall_o), 32'(st));
  endtask

  initial begin
    // 1: reset held two cycles with both requesters active
    reset_i = 1'b1;
    wb(1'b1, 5'd3, 32'h33);
    push(5'd4, 32'h44);
    #1;
    for (int i = 0; i < 2; i++) begin
      settle();
      expect_wr("rst", 1'b0, 5'd0, 32'h0, 1'b0);
      check("rst.ready", 32'(bus.lu_ready_o), 32'd0);
      tick();
    end
    reset_i = 1'b0;
    bus.lu_valid_i = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    settle();
    check("rst.count", 32'(dut.u_fifo.count_q), 32'd0);
    check("rst.ready_rel", 32'(bus.lu_ready_o), 32'd1);

    // 2: idle port, no bypass, written the following cycle
    push(5'd5, 32'hDEADBEEF);
    settle();
    check("idle.nobypass", 32'(bus.rf_we_o), 32'd0);
    tick();
    bus.lu_valid_i = 1'b0;
    settle();
    expect_wr("idle.wr", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    check("idle.count", 32'(dut.u_fifo.count_q), 32'd0);

    // 3/4: pipeline priority, full FIFO, two forced drains
    wb(1'b1, 5'd3, 32'h33);
    push(5'd7, 32'h70);
    settle();
    expect_wr("pri.a0", 1'b1, 5'd3, 32'h33, 1'b0);
    tick();
    push(5'd8, 32'h80);
    settle();
    check("pri.ready1", 32'(bus.lu_ready_o), 32'd1);
    expect_wr("pri.a1", 1'b1, 5'd3, 32'h33, 1'b0);
    tick();
    bus.lu_valid_i = 1'b0;
    settle();
    check("pri.full", 32'(bus.lu_ready_o), 32'd0);
    for (int i = 2; i < 5; i++) begin
      expect_wr($sformatf("starve.loss%0d", i), 1'b1, 5'd3, 32'h33, 1'b0);
      tick();
    end
    expect_wr("starve.force7", 1'b1, 5'd7, 32'h70, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_wr($sformatf("starve.resume%0d", i), 1'b1, 5'd3, 32'h33, 1'b0);
      tick();
    end
    expect_wr("starve.force8", 1'b1, 5'd8, 32'h80, 1'b1);
    tick();
    expect_wr("starve.after", 1'b1, 5'd3, 32'h33, 1'b0);
    check("starve.count", 32'(dut.u_fifo.count_q), 32'd0);
    wb(1'b0, 5'd0, 32'h0);
    tick();

    // 5: x0 handling on both sides
    push(5'd0, 32'h12345678);
    settle();
    check("x0.ready", 32'(bus.lu_ready_o), 32'd1);
    tick();
    bus.lu_valid_i = 1'b0;
    wb(1'b1, 5'd0, 32'h55);
    settle();
    check("x0.nowr", 32'(bus.rf_we_o), 32'd0);
    check("x0.count", 32'(dut.u_fifo.count_q), 32'd0);
    push(5'd9, 32'h99);
    tick();
    bus.lu_valid_i = 1'b0;
    settle();
    expect_wr("x0.lu9", 1'b1, 5'd9, 32'h99, 1'b0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    settle();
    check("x0.count2", 32'(dut.u_fifo.count_q), 32'd0);

    // 6: push and pop in the same cycle keep count at 1, order preserved
    wb(1'b1, 5'd3, 32'h33);
    push(5'd10, 32'hA0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    push(5'd11, 32'hB0);
    settle();
    expect_wr("pp.head10", 1'b1, 5'd10, 32'hA0, 1'b0);
    tick();
    bus.lu_valid_i = 1'b0;
    settle();
    check("pp.count", 32'(dut.u_fifo.count_q), 32'd1);
    expect_wr("pp.head11", 1'b1, 5'd11, 32'hB0, 1'b0);
    tick();
    check("pp.empty", 32'(dut.u_fifo.count_q), 32'd0);

    // 6b: reset with two pending entries drops them
    wb(1'b1, 5'd3, 32'h33);
    push(5'd12, 32'hC0);
    tick();
    push(5'd13, 32'hD0);
    tick();
    bus.lu_valid_i = 1'b0;
    settle();
    check("rstmid.count2", 32'(dut.u_fifo.count_q), 32'd2);
    reset_i = 1'b1;
    settle();
    expect_wr("rstmid.inrst", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    reset_i = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    settle();
    check("rstmid.count0", 32'(dut.u_fifo.count_q), 32'd0);
    check("rstmid.nowr", 32'(bus.rf_we_o), 32'd0);
    tick();
    check("rstmid.nowr2", 32'(bus.rf_we_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
